// File: rtl/seg7_pkg.sv
// Shared types and segment patterns for the seg7 scan driver.
// Define SEG7_HEX_EN to decode codes 10..15 as A,b,C,d,E,F; otherwise they blank.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_e;

`ifdef SEG7_HEX_EN
  localparam logic [6:0] SEG_HEX_A = 7'b1110111;
  localparam logic [6:0] SEG_HEX_B = 7'b1111100;
  localparam logic [6:0] SEG_HEX_C = 7'b0111001;
  localparam logic [6:0] SEG_HEX_D = 7'b1011110;
  localparam logic [6:0] SEG_HEX_E = 7'b1111001;
  localparam logic [6:0] SEG_HEX_F = 7'b1110001;
`else
  localparam logic [6:0] SEG_HEX_A = 7'b0000000;
  localparam logic [6:0] SEG_HEX_B = 7'b0000000;
  localparam logic [6:0] SEG_HEX_C = 7'b0000000;
  localparam logic [6:0] SEG_HEX_D = 7'b0000000;
  localparam logic [6:0] SEG_HEX_E = 7'b0000000;
  localparam logic [6:0] SEG_HEX_F = 7'b0000000;
`endif

  // Patterns are {g,f,e,d,c,b,a}, indexed by the 4-bit digit code.
  localparam logic [6:0] SEG_PAT [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, SEG_HEX_A,  SEG_HEX_B,
    SEG_HEX_C,  SEG_HEX_D,  SEG_HEX_E,  SEG_HEX_F
  };

  function automatic logic [6:0] seg7_lookup(input logic [3:0] code);
    return SEG_PAT[code];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit code to 7-segment pattern decoder.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] pattern_o
);

  assign pattern_o = seg7_lookup(code_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver: blank/show slot per digit, shadowed input value.
// Hex digits A..F are decoded only when SEG7_HEX_EN is defined.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int BLANK_CYC  = 2,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] val_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    enable,
  output logic [6:0]              seg,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    busy
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BSY_W = $clog2(NUM_DIGITS + 1);

  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BSY_W-1:0] BSY_LAST   = BSY_W'(NUM_DIGITS - 1);
  localparam scan_state_e      SLOT_START = (BLANK_CYC == 0) ? SHOW : BLANK;
  localparam logic             POL        = (ACTIVE_LOW != 0);

  scan_state_e                 state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0]     shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0]       shadow_dp_q, shadow_dp_d;
  logic [3:0]                  cur_code_q, cur_code_d;
  logic                        cur_dp_q, cur_dp_d;
  logic                        busy_q, busy_d;
  logic                        fresh_q, fresh_d;
  logic [BSY_W-1:0]            bcnt_q, bcnt_d;
  logic [6:0]                  seg_q, seg_d;
  logic                        dp_q, dp_d;
  logic [NUM_DIGITS-1:0]       dig_q, dig_d;

  logic                        slot_end;
  logic                        show_entry;
  logic                        showing;
  logic [6:0]                  pattern;

  // NOTE: every always_comb assigns all its outputs a default first, so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    slot_end = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = SLOT_START;
          cnt_d   = '0;
        end
        BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BLANK_LAST) state_d = SHOW;
        end
        SHOW: begin
          if (cnt_q == SLOT_LAST) begin
            slot_end = 1'b1;
            state_d  = SLOT_START;
            cnt_d    = '0;
            idx_d    = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign show_entry = (state_d == SHOW) && ((state_q != SHOW) || slot_end);

  // The displayed nibble is latched only on SHOW entry, from the post-load shadow value.
  always_comb begin
    shadow_val_d = load ? val_in : shadow_val_q;
    shadow_dp_d  = load ? dp_in  : shadow_dp_q;
    cur_code_d   = cur_code_q;
    cur_dp_d     = cur_dp_q;
    if (show_entry) begin
      cur_code_d = shadow_val_d[4*int'(idx_d) +: 4];
      cur_dp_d   = shadow_dp_d[int'(idx_d)];
    end
  end

  // fresh_q marks that a SHOW phase has latched the current shadow since the last load.
  always_comb begin
    busy_d  = busy_q;
    bcnt_d  = bcnt_q;
    fresh_d = fresh_q;
    if (load) begin
      busy_d  = 1'b1;
      bcnt_d  = '0;
      fresh_d = show_entry;
    end else begin
      if (slot_end && fresh_q && busy_q) begin
        if (bcnt_q == BSY_LAST) begin
          busy_d = 1'b0;
          bcnt_d = '0;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      if (show_entry) fresh_d = 1'b1;
    end
  end

  seg7_decode u_decode (
    .code_i    (cur_code_q),
    .pattern_o (pattern)
  );

  assign showing = enable && (state_q == SHOW);

  always_comb begin
    seg_d = showing ? pattern : 7'b0;
    dp_d  = showing && cur_dp_q;
    dig_d = showing ? (NUM_DIGITS'(1) << idx_q) : '0;
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      // NOTE: the shadow and latched-digit registers are reset too, so digit 0 shows a defined 0 after reset.
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      cur_code_q   <= '0;
      cur_dp_q     <= 1'b0;
      busy_q       <= 1'b0;
      fresh_q      <= 1'b0;
      bcnt_q       <= '0;
      seg_q        <= '0;
      dp_q         <= 1'b0;
      dig_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      cur_code_q   <= cur_code_d;
      cur_dp_q     <= cur_dp_d;
      busy_q       <= busy_d;
      fresh_q      <= fresh_d;
      bcnt_q       <= bcnt_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      dig_q        <= dig_d;
    end
  end

  assign seg    = seg_q ^ {7{POL}};
  assign dp_out = dp_q ^ POL;
  assign dig_en = dig_q ^ {NUM_DIGITS{POL}};
  assign busy   = busy_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (4 digits, 8-cycle slot, 2 blank cycles).
// Each displayed slot is captured as {dig_en, seg, dp, cycles on} and compared in order.
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int BC = 2;
  localparam int ON_CYC = SD - BC;

`ifdef SEG7_HEX_EN
  localparam logic [6:0] EXP_A = 7'b1110111;
  localparam logic [6:0] EXP_C = 7'b0111001;
  localparam logic [6:0] EXP_F = 7'b1110001;
`else
  localparam logic [6:0] EXP_A = 7'b0000000;
  localparam logic [6:0] EXP_C = 7'b0000000;
  localparam logic [6:0] EXP_F = 7'b0000000;
`endif

  logic          clk;
  logic          rst;
  logic          load;
  logic          enable;
  logic [15:0]   val_in;
  logic [ND-1:0] dp_in;
  logic [6:0]    seg, seg_al;
  logic          dp_out, dp_al;
  logic [ND-1:0] dig_en, dig_al;
  logic          busy, busy_al;

  int n_vec = 0;
  int n_err = 0;
  bit mon_on = 1'b0;

  typedef struct packed {
    logic [3:0] dig;
    logic [6:0] seg;
    logic       dp;
    logic [7:0] len;
  } slot_t;

  slot_t exp_q[$];

  seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC), .ACTIVE_LOW(0)) u_dut (
    .clk(clk), .rst(rst), .load(load), .val_in(val_in), .dp_in(dp_in), .enable(enable),
    .seg(seg), .dp_out(dp_out), .dig_en(dig_en), .busy(busy)
  );

  seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC), .ACTIVE_LOW(1)) u_dut_al (
    .clk(clk), .rst(rst), .load(load), .val_in(val_in), .dp_in(dp_in), .enable(enable),
    .seg(seg_al), .dp_out(dp_al), .dig_en(dig_al), .busy(busy_al)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_slot(input logic [3:0] dig, input logic [6:0] sg, input logic dp,
                           input int len);
    slot_t s;
    s.dig = dig;
    s.seg = sg;
    s.dp  = dp;
    s.len = 8'(len);
    exp_q.push_back(s);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance to the next negedge at which dig_en is active (on=1) or inactive (on=0).
  task automatic wait_dig(input bit on, input string what);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((dig_en !== '0) != on) && n < 64);
    if ((dig_en !== '0) != on) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout %s: dig_en=%b after %0d cycles", what, dig_en, n);
    end
  endtask

  initial begin : monitor
    slot_t cur;
    slot_t exp;
    int    len;
    len = 0;
    cur = '0;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (len > 0 && (dig_en !== cur.dig || seg !== cur.seg || dp_out !== cur.dp)) begin
          cur.len = 8'(len);
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_slot: dig=%b seg=%b dp=%b len=%0d", cur.dig, cur.seg,
                     cur.dp, len);
          end else begin
            exp = exp_q.pop_front();
            check($sformatf("slot dig=%b seg=%b dp=%b len=%0d", exp.dig, exp.seg, exp.dp, exp.len),
                  32'(cur), 32'(exp));
          end
          len = 0;
        end
        if (dig_en !== '0) begin
          if (len == 0) begin
            cur.dig = dig_en;
            cur.seg = seg;
            cur.dp  = dp_out;
          end
          len++;
        end
      end
    end
  end

  initial begin : stim
    int  n;
    bit  exp_busy3 [5];
    rst    = 1'b1;
    enable = 1'b1;
    load   = 1'b0;
    val_in = '0;
    dp_in  = '0;

    // Reset held for three edges with enable high.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset seg", 32'(seg), 32'h0);
    check("reset dig_en", 32'(dig_en), 32'h0);
    check("reset dp_out", 32'(dp_out), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset active_low seg", 32'(seg_al), 32'h7F);
    check("reset active_low dig_en", 32'(dig_al), 32'hF);
    check("reset active_low dp_out", 32'(dp_al), 32'h1);
    check("reset active_low busy", 32'(busy_al), 32'h0);
    mon_on = 1'b1;

    // Scan order: 1234 with dp on digit 2, loaded on the first edge out of reset.
    rst    = 1'b0;
    load   = 1'b1;
    val_in = 16'h1234;
    dp_in  = 4'b0100;
    push_slot(4'b0001, 7'b1100110, 1'b0, ON_CYC);
    push_slot(4'b0010, 7'b1001111, 1'b0, ON_CYC);
    push_slot(4'b0100, 7'b1011011, 1'b1, ON_CYC);
    push_slot(4'b1000, 7'b0000110, 1'b0, ON_CYC);
    @(negedge clk);
    load = 1'b0;
    n = 1;
    check("busy after load", 32'(busy), 32'h1);
    while (dig_en === '0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    // IDLE->BLANK edge, BLANK_CYC blank cycles, then one output-register cycle.
    check("first show latency", 32'(n), 32'(BC + 2));
    check("active_low seg digit0", 32'(seg_al), 32'h19);
    check("active_low dig_en digit0", 32'(dig_al), 32'hE);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) wait_dig(1'b1, "scan rise");
      wait_dig(1'b0, "scan fall");
      check($sformatf("busy at end of scan slot %0d", k), 32'(busy), (k < 3) ? 32'h1 : 32'h0);
    end
    enable = 1'b0;

    // Load while disabled: captured, busy held; then a mid-slot reload of digit 0.
    idle(2);
    load   = 1'b1;
    val_in = 16'hFCA8;
    dp_in  = 4'b0001;
    @(negedge clk);
    load = 1'b0;
    idle(5);
    check("busy held while disabled", 32'(busy), 32'h1);
    push_slot(4'b0001, 7'b1111111, 1'b1, ON_CYC);
    push_slot(4'b0010, EXP_A,      1'b0, ON_CYC);
    push_slot(4'b0100, EXP_C,      1'b0, ON_CYC);
    push_slot(4'b1000, EXP_F,      1'b0, ON_CYC);
    push_slot(4'b0001, 7'b0111111, 1'b0, ON_CYC);
    enable = 1'b1;
    wait_dig(1'b1, "hex rise");
    idle(2);
    load   = 1'b1;
    val_in = 16'hFCA0;
    dp_in  = 4'b0000;
    @(negedge clk);
    load = 1'b0;
    // The mid-slot reload restarts the count; the stale digit-0 slot does not count.
    exp_busy3 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 5; k++) begin
      if (k > 0) wait_dig(1'b1, "reload rise");
      wait_dig(1'b0, "reload fall");
      check($sformatf("busy at end of reload slot %0d", k), 32'(busy), 32'(exp_busy3[k]));
    end
    enable = 1'b0;

    // Disable mid-SHOW of digit 1, then resume at the same digit after blanking.
    idle(3);
    push_slot(4'b0010, EXP_A, 1'b0, 2);
    push_slot(4'b0010, EXP_A, 1'b0, ON_CYC);
    enable = 1'b1;
    wait_dig(1'b1, "enable rise");
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("dig_en off after disable", 32'(dig_en), 32'h0);
    idle(3);
    enable = 1'b1;
    wait_dig(1'b1, "resume rise");
    wait_dig(1'b0, "resume fall");
    enable = 1'b0;

    // Reset mid-SHOW of digit 2; the scan restarts at digit 0 with cleared shadow.
    idle(3);
    push_slot(4'b0100, EXP_C, 1'b0, 2);
    enable = 1'b1;
    wait_dig(1'b1, "pre-reset rise");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid-show reset dig_en", 32'(dig_en), 32'h0);
    check("mid-show reset seg", 32'(seg), 32'h0);
    @(negedge clk);
    check("mid-show reset busy", 32'(busy), 32'h0);
    push_slot(4'b0001, 7'b0111111, 1'b0, ON_CYC);
    push_slot(4'b0010, 7'b1101111, 1'b0, ON_CYC);
    rst = 1'b0;
    wait_dig(1'b1, "post-reset rise");
    // Load lands on the edge that ends digit 0's SHOW; digit 1 must show the new 9.
    idle(4);
    load   = 1'b1;
    val_in = 16'h0090;
    dp_in  = 4'b0000;
    @(negedge clk);
    load = 1'b0;
    wait_dig(1'b0, "boundary fall 0");
    wait_dig(1'b1, "boundary rise 1");
    wait_dig(1'b0, "boundary fall 1");
    check("busy after one fresh slot", 32'(busy), 32'h1);
    enable = 1'b0;

    idle(4);
    check("scoreboard drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
